// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the uart_rx controller
package uart_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } rx_state_e;

  localparam int INTR_WMARK = 0;
  localparam int INTR_OVF   = 1;
  localparam int INTR_TMO   = 2;
  localparam int INTR_CFG   = 3;

  // uart_rx samples with an 8-bit counter, so bit periods outside this range break it
  localparam int CPB_MIN = 4;
  localparam int CPB_MAX = 256;

  function automatic logic cpb_legal(input logic [15:0] cpb);
    return (int'(cpb) >= CPB_MIN) && (int'(cpb) <= CPB_MAX);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8-bit first-word-fall-through receive FIFO
module uart_rx_fifo #(
  parameter int DEPTH   = 16,
  parameter int DEPTH_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               clr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata,
  output logic [DEPTH_W:0]   level,
  output logic               full,
  output logic               empty
);

  logic [7:0]         mem [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W-1:0] rd_ptr;
  logic [DEPTH_W:0]   cnt;
  logic               do_push;
  logic               do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (DEPTH_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign do_push = push && (!full || do_pop);
  assign level   = cnt;
  assign rdata   = empty ? 8'h00 : mem[rd_ptr];

  // pointer and occupancy tracking; flush overrides push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (DEPTH_W+1)'(1);
        2'b01:   cnt <= cnt - (DEPTH_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // storage array; contents need no reset because occupancy gates the read side
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - uart_rx enable/config sequencing, receive buffering and interrupts
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter  int FIFO_DEPTH = 16,
  localparam int DEPTH_W    = $clog2(FIFO_DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cfg_en_i,
  input  logic [15:0]        cfg_clks_per_bit_i,
  input  logic [DEPTH_W-1:0] cfg_wmark_i,
  input  logic [7:0]         cfg_timeout_i,
  input  logic               fifo_clr_i,
  input  logic               rd_pop_i,
  output logic [7:0]         rd_data_o,
  output logic               rd_valid_o,
  output logic [DEPTH_W:0]   fifo_level_o,
  input  logic [3:0]         intr_clr_i,
  output logic [3:0]         intr_o,
  output logic               core_rx_en_o,
  output logic [15:0]        core_clks_per_bit_o,
  input  logic               core_dv_i,
  input  logic [7:0]         core_byte_i
);

  rx_state_e   state;
  logic [15:0] shadow;
  logic        rx_en;
  logic        in_run;
  logic        push_req;
  logic        fifo_full;
  logic        fifo_empty;
  logic [15:0] tick_cnt;
  logic        tick;
  logic [7:0]  idle_cnt;
  logic [7:0]  idle_next;
  logic        idle_zero;
  logic [3:0]  intr_set;
  logic [3:0]  intr_q;

  assign in_run              = (state == ST_RUN);
  assign push_req            = core_dv_i && in_run;
  assign core_rx_en_o        = rx_en;
  assign core_clks_per_bit_o = shadow;
  assign rd_valid_o          = !fifo_empty;
  assign intr_o              = intr_q;

  uart_rx_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .DEPTH_W (DEPTH_W)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push_req),
    .pop   (rd_pop_i),
    .clr   (fifo_clr_i),
    .wdata (core_byte_i),
    .rdata (rd_data_o),
    .level (fifo_level_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // enable sequencing: validate and capture the bit period once per enable
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= ST_OFF;
      rx_en  <= 1'b0;
      shadow <= 16'd4;
    end else begin
      case (state)
        ST_OFF: begin
          rx_en <= 1'b0;
          if (cfg_en_i) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (cpb_legal(cfg_clks_per_bit_i)) begin
            shadow <= cfg_clks_per_bit_i;
            rx_en  <= 1'b1;
            state  <= ST_RUN;
          end else begin
            rx_en  <= 1'b0;
            state  <= ST_HOLD;
          end
        end
        ST_RUN: begin
          if (!cfg_en_i) begin
            rx_en <= 1'b0;
            state <= ST_OFF;
          end else begin
            rx_en <= 1'b1;
          end
        end
        ST_HOLD: begin
          rx_en <= 1'b0;
          if (!cfg_en_i) state <= ST_OFF;
        end
        default: begin
          rx_en <= 1'b0;
          state <= ST_OFF;
        end
      endcase
    end
  end

  // the idle measurement restarts whenever the bus side or core shows activity
  assign idle_zero = !in_run || core_dv_i || rd_pop_i || fifo_clr_i || fifo_empty;
  assign tick      = in_run && (tick_cnt == shadow - 16'd1);

  // next idle count: saturate at the programmed timeout (or at all-ones when disabled)
  always_comb begin
    idle_next = idle_cnt;
    if (idle_zero) begin
      idle_next = 8'd0;
    end else if (tick && (idle_cnt != cfg_timeout_i) && (idle_cnt != 8'hFF)) begin
      idle_next = idle_cnt + 8'd1;
    end
  end

  // bit-period ticks are phased from the last activity so the timeout is an exact bit count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt <= 16'd0;
      idle_cnt <= 8'd0;
    end else begin
      idle_cnt <= idle_next;
      if (idle_zero || tick) tick_cnt <= 16'd0;
      else                   tick_cnt <= tick_cnt + 16'd1;
    end
  end

  // interrupt set conditions for this cycle
  always_comb begin
    intr_set             = 4'b0000;
    intr_set[INTR_WMARK] = fifo_level_o > {1'b0, cfg_wmark_i};
    intr_set[INTR_OVF]   = push_req && fifo_full && !rd_pop_i && !fifo_clr_i;
    intr_set[INTR_TMO]   = (cfg_timeout_i != 8'd0) && (idle_next == cfg_timeout_i);
    intr_set[INTR_CFG]   = (state == ST_LOAD) && !cpb_legal(cfg_clks_per_bit_i);
  end

  // sticky interrupt bits; a set in the same cycle beats a clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) intr_q <= 4'b0000;
    else         intr_q <= (intr_q & ~intr_clr_i) | intr_set;
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed scoreboard bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_en;
  logic [15:0] cfg_cpb;
  logic [3:0]  cfg_wmark;
  logic [7:0]  cfg_timeout;
  logic        fifo_clr;
  logic        rd_pop;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [4:0]  fifo_level;
  logic [3:0]  intr_clr;
  logic [3:0]  intr;
  logic        core_rx_en;
  logic [15:0] core_cpb;
  logic        core_dv;
  logic [7:0]  core_byte;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  uart_rx_ctrl #(.FIFO_DEPTH(16)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .cfg_en_i            (cfg_en),
    .cfg_clks_per_bit_i  (cfg_cpb),
    .cfg_wmark_i         (cfg_wmark),
    .cfg_timeout_i       (cfg_timeout),
    .fifo_clr_i          (fifo_clr),
    .rd_pop_i            (rd_pop),
    .rd_data_o           (rd_data),
    .rd_valid_o          (rd_valid),
    .fifo_level_o        (fifo_level),
    .intr_clr_i          (intr_clr),
    .intr_o              (intr),
    .core_rx_en_o        (core_rx_en),
    .core_clks_per_bit_o (core_cpb),
    .core_dv_i           (core_dv),
    .core_byte_i         (core_byte)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accepted);
    core_dv   = 1'b1;
    core_byte = b;
    if (accepted) sb.push_back(b);
    @(negedge clk);
    core_dv   = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
    end else begin
      exp = sb.pop_front();
      chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
      chk(tag, 32'(rd_data), 32'(exp));
    end
    rd_pop = 1'b1;
    @(negedge clk);
    rd_pop = 1'b0;
  endtask

  task automatic clear_intr();
    intr_clr = 4'hF;
    @(negedge clk);
    intr_clr = 4'h0;
  endtask

  task automatic enable_cycle(input logic [15:0] cpb);
    cfg_en  = 1'b0;
    step(2);
    cfg_cpb = cpb;
    cfg_en  = 1'b1;
    step(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_en = 1'b0; cfg_cpb = 16'd16; cfg_wmark = 4'd15; cfg_timeout = 8'd0;
    fifo_clr = 1'b0; rd_pop = 1'b0; intr_clr = 4'h0; core_dv = 1'b0; core_byte = 8'h00;
    step(3);
    chk("rst_rx_en", 32'(core_rx_en), 32'd0);
    chk("rst_cpb", 32'(core_cpb), 32'd4);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_intr", 32'(intr), 32'd0);
    rst_n = 1'b1;
    step(1);

    // basic enable and two-byte transfer
    cfg_en = 1'b1;
    step(2);
    chk("en_rx_en", 32'(core_rx_en), 32'd1);
    chk("en_cpb", 32'(core_cpb), 32'd16);
    push_byte(8'hA5, 1'b1);
    push_byte(8'h3C, 1'b1);
    chk("two_level", 32'(fifo_level), 32'd2);
    pop_check("pop_a5");
    pop_check("pop_3c");
    chk("drain_valid", 32'(rd_valid), 32'd0);
    chk("drain_data", 32'(rd_data), 32'd0);

    // overflow: 17 pushes into 16 entries
    for (int i = 0; i < 17; i++) push_byte(8'h10 + 8'(i), i < 16);
    chk("full_level", 32'(fifo_level), 32'd16);
    chk("ovf_intr", 32'(intr[1]), 32'd1);
    chk("wmark_intr", 32'(intr[0]), 32'd1);
    clear_intr();
    chk("ovf_cleared", 32'(intr[1]), 32'd0);

    // full FIFO, simultaneous push and pop
    begin
      logic [7:0] exp_head;
      exp_head = sb.pop_front();
      chk("pp_head", 32'(rd_data), 32'(exp_head));
      sb.push_back(8'h77);
      rd_pop = 1'b1; core_dv = 1'b1; core_byte = 8'h77;
      @(negedge clk);
      rd_pop = 1'b0; core_dv = 1'b0;
    end
    chk("pp_level", 32'(fifo_level), 32'd16);
    chk("pp_no_ovf", 32'(intr[1]), 32'd0);

    // watermark set wins over its clear
    intr_clr = 4'b0001;
    step(1);
    intr_clr = 4'b0000;
    chk("wmark_set_wins", 32'(intr[0]), 32'd1);
    for (int i = 0; i < 16; i++) pop_check($sformatf("drain%0d", i));
    chk("drained_valid", 32'(rd_valid), 32'd0);

    // idle timeout: cpb 8, timeout 4 bit periods
    enable_cycle(16'd8);
    chk("tmo_cpb", 32'(core_cpb), 32'd8);
    cfg_timeout = 8'd4;
    clear_intr();
    chk("tmo_intr_clear", 32'(intr), 32'd0);
    push_byte(8'h5A, 1'b1);
    step(31);
    chk("tmo_early", 32'(intr[2]), 32'd0);
    step(1);
    chk("tmo_exact", 32'(intr[2]), 32'd1);
    pop_check("tmo_pop");
    clear_intr();
    push_byte(8'hC3, 1'b1);
    step(20);
    pop_check("tmo_pop_early");
    step(40);
    chk("tmo_avoided", 32'(intr[2]), 32'd0);

    // shadow only updates on re-enable
    cfg_cpb = 16'd32;
    step(3);
    chk("shadow_hold", 32'(core_cpb), 32'd8);
    enable_cycle(16'd32);
    chk("shadow_reload", 32'(core_cpb), 32'd32);
    chk("shadow_rx_en", 32'(core_rx_en), 32'd1);

    // illegal bit periods
    enable_cycle(16'd3);
    chk("cpb3_err", 32'(intr[3]), 32'd1);
    chk("cpb3_rx_en", 32'(core_rx_en), 32'd0);
    chk("cpb3_shadow", 32'(core_cpb), 32'd32);
    cfg_en = 1'b0;
    step(2);
    clear_intr();
    enable_cycle(16'd257);
    chk("cpb257_err", 32'(intr[3]), 32'd1);
    chk("cpb257_rx_en", 32'(core_rx_en), 32'd0);
    cfg_en = 1'b0;
    step(2);
    clear_intr();
    enable_cycle(16'd256);
    chk("cpb256_rx_en", 32'(core_rx_en), 32'd1);
    chk("cpb256_cpb", 32'(core_cpb), 32'd256);
    chk("cpb256_no_err", 32'(intr[3]), 32'd0);

    // asynchronous reset with bytes queued
    push_byte(8'h01, 1'b1);
    push_byte(8'h02, 1'b1);
    push_byte(8'h03, 1'b1);
    chk("pre_rst_level", 32'(fifo_level), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_rx_en", 32'(core_rx_en), 32'd0);
    chk("arst_cpb", 32'(core_cpb), 32'd4);
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_valid", 32'(rd_valid), 32'd0);
    chk("arst_data", 32'(rd_data), 32'd0);
    chk("arst_intr", 32'(intr), 32'd0);
    sb.delete();
    step(2);
    rst_n = 1'b1;
    step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
